// File: rtl/keypad_time_encoder.sv
// rtl/keypad_time_encoder.sv - keypad debounce and BCD min:sec entry with valid/ready handoff
// Debounces a 12-key panel, shifts digits into m:ss BCD and offers the time to the countdown timer.
module keypad_time_encoder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] key,
  input  logic        enable,
  input  logic        time_ready,
  output logic [3:0]  min,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        time_valid,
  output logic        digit_stb,
  output logic        key_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int KEY_START = 10;
  localparam int KEY_CLEAR = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEB  = 2'd1,
    ST_REL  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [11:0]   key_m_q, key_s_q;
  logic [11:0]   cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    min_q, min_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          valid_q, valid_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;
  logic [3:0]    cand_digit;
  logic          time_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m_q <= '0;
      key_s_q <= '0;
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      min_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      key_m_q <= key;
      key_s_q <= key_m_q;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      valid_q <= valid_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cand_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (cand_q[i]) cand_digit = 4'(i);
    end
  end

  assign time_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    valid_d = valid_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ($onehot(key_s_q)) begin
          cand_d  = key_s_q;
          cnt_d   = '0;
          state_d = ST_DEB;
        end
      end

      ST_DEB: begin
        if (key_s_q != cand_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_REL;
          cnt_d   = '0;
          if (cand_q[KEY_CLEAR]) begin
            min_d  = 4'd0;
            tens_d = 4'd0;
            ones_d = 4'd0;
            stb_d  = 1'b1;
          end else if (cand_q[KEY_START]) begin
            if (enable) begin
              if (time_zero) begin
                err_d = 1'b1;
              end else begin
                state_d = ST_HOLD;
                valid_d = 1'b1;
              end
            end
          end else if (enable) begin
            // The old ones digit becomes sec_tens, so it must not exceed 5.
            if (ones_q <= 4'd5) begin
              min_d  = tens_q;
              tens_d = ones_q;
              ones_d = cand_digit;
              stb_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_REL: begin
        if (key_s_q != 12'd0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (valid_q && time_ready) begin
          valid_d = 1'b0;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          cnt_d   = '0;
          state_d = ST_REL;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign min        = min_q;
  assign sec_tens   = tens_q;
  assign sec_ones   = ones_q;
  assign time_valid = valid_q;
  assign digit_stb  = stb_q;
  assign key_err    = err_q;

endmodule

// File: tb/tb_keypad_time_encoder.sv
// tb/tb_keypad_time_encoder.sv - directed self-checking bench for keypad_time_encoder
module tb_keypad_time_encoder;

  logic        clk;
  logic        rst_n;
  logic [11:0] key;
  logic        enable;
  logic        time_ready;
  logic [3:0]  min, sec_tens, sec_ones;
  logic        time_valid, digit_stb, key_err;

  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int s0, e0;

  localparam logic [11:0] K_START = 12'h400;
  localparam logic [11:0] K_CLEAR = 12'h800;

  keypad_time_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .enable     (enable),
    .time_ready (time_ready),
    .min        (min),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .time_valid (time_valid),
    .digit_stb  (digit_stb),
    .key_err    (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (digit_stb) stb_cnt++;
      if (key_err) err_cnt++;
      if (digit_stb && key_err) both_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tval();
    return {min, sec_tens, sec_ones};
  endfunction

  task automatic press(input logic [11:0] code, input int hold, input int rel);
    key = code;
    repeat (hold) @(negedge clk);
    key = 12'd0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic digit(input int d);
    logic [11:0] code;
    code = 12'd1 << d;
    press(code, 10, 10);
  endtask

  initial begin
    rst_n = 1'b0;
    key = 12'd0;
    enable = 1'b1;
    time_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_time", tval(), 'h000);
    chk("reset_valid", time_valid, 0);
    chk("reset_stb_err", {digit_stb, key_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Entry with latency check on the first digit
    s0 = stb_cnt;
    key = 12'd1 << 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("lat_before_edge7", tval(), 'h000);
    @(posedge clk);
    @(negedge clk);
    chk("lat_edge7_time", tval(), 'h001);
    chk("lat_edge7_stb", digit_stb, 1);
    @(negedge clk);
    chk("stb_one_cycle", digit_stb, 0);
    repeat (8) @(negedge clk);
    key = 12'd0;
    repeat (10) @(negedge clk);
    digit(2);
    digit(3);
    chk("entry_123", tval(), 'h123);
    chk("entry_stb_count", stb_cnt - s0, 3);

    // Reset mid-debounce with key 4 held
    key = 12'd1 << 4;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_time", tval(), 'h000);
    chk("rst_mid_flags", {time_valid, digit_stb, key_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_redeb_early", tval(), 'h000);
    @(posedge clk);
    @(negedge clk);
    chk("rst_redeb_commit", tval(), 'h004);
    key = 12'd0;
    repeat (10) @(negedge clk);

    // Bounce then two keys together
    s0 = stb_cnt; e0 = err_cnt;
    press(12'd1 << 5, 3, 10);
    press((12'd1 << 4) | (12'd1 << 6), 10, 10);
    chk("bounce_time", tval(), 'h004);
    chk("bounce_stb", stb_cnt - s0, 0);
    chk("bounce_err", err_cnt - e0, 0);

    // Range: 0:17 then 8 rejected, then CLEAR
    press(K_CLEAR, 10, 10);
    digit(1);
    digit(7);
    chk("range_017", tval(), 'h017);
    s0 = stb_cnt; e0 = err_cnt;
    digit(8);
    chk("range_err", err_cnt - e0, 1);
    chk("range_kept", tval(), 'h017);
    chk("range_no_stb", stb_cnt - s0, 0);
    press(K_CLEAR, 10, 10);
    chk("clear_time", tval(), 'h000);
    chk("clear_stb", stb_cnt - s0, 1);

    // Handshake with time_ready held low
    digit(1);
    digit(2);
    digit(3);
    time_ready = 1'b0;
    press(K_START, 10, 10);
    chk("hold_valid", time_valid, 1);
    chk("hold_time", tval(), 'h123);
    s0 = stb_cnt;
    digit(9);
    chk("hold_ignore_time", tval(), 'h123);
    chk("hold_ignore_valid", time_valid, 1);
    chk("hold_ignore_stb", stb_cnt - s0, 0);
    time_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("xfer_valid", time_valid, 0);
    chk("xfer_time", tval(), 'h000);
    time_ready = 1'b0;
    repeat (10) @(negedge clk);

    // Gating
    s0 = stb_cnt; e0 = err_cnt;
    enable = 1'b0;
    digit(9);
    chk("gate_time", tval(), 'h000);
    chk("gate_stb", stb_cnt - s0, 0);
    enable = 1'b1;
    press(K_START, 10, 10);
    chk("start_zero_err", err_cnt - e0, 1);
    chk("start_zero_valid", time_valid, 0);
    chk("stb_err_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
